// File: rtl/ts_psg_mixer.sv
// ts_psg_mixer: stereo mixer for CHANNELS AY PSGs plus the FE beeper.
// Optional macro TS_PSG_MIXER_DCBLOCK_EN adds a per-side DC blocker (signed out).
module ts_psg_mixer #(
  parameter int CHANNELS = 2,
  parameter int DW       = 12,
  parameter int OW       = 16,
  localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [1:0]             mode,
  input  logic                   selWr,
  input  logic [7:0]             d,
  output logic [SW-1:0]          sel,
  input  logic [1:0]             beep,
  input  logic [CHANNELS*DW-1:0] psgA,
  input  logic [CHANNELS*DW-1:0] psgB,
  input  logic [CHANNELS*DW-1:0] psgC,
  output logic [OW-1:0]          left,
  output logic [OW-1:0]          right,
  output logic                   valid
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam logic [SW-1:0] KLAST = SW'(CHANNELS - 1);

  state_t        state, state_n;
  logic [SW-1:0] k;
  logic          pending;
  logic [1:0]    mode_q;
  logic [OW:0]   accl, accr, accl_n, accr_n;
  logic [OW+1:0] suml, sumr;
  logic [11:0]   blvl;
  logic [DW+1:0] a, b, c, tl, tr;
  logic [OW-1:0] satl, satr;
  logic          start;

  assign start = (state == IDLE) && (ce || pending);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ce || pending) state_n = ACC;
      ACC:     if (k == KLAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    blvl = 12'd0;
    unique case (beep)
      2'd3:    blvl = 12'd4095;
      2'd2:    blvl = 12'd3874;
      2'd1:    blvl = 12'd775;
      default: blvl = 12'd0;
    endcase
  end

  always_comb begin
    a  = (DW+2)'(psgA[int'(k)*DW +: DW]);
    b  = (DW+2)'(psgB[int'(k)*DW +: DW]);
    c  = (DW+2)'(psgC[int'(k)*DW +: DW]);
    tl = '0;
    tr = '0;
    unique case (mode_q)
      2'd0: begin
        tl = (a << 1) + b;
        tr = (c << 1) + b;
      end
      2'd1: begin
        tl = (a << 1) + c;
        tr = (b << 1) + c;
      end
      default: begin
        tl = a + b + c;
        tr = a + b + c;
      end
    endcase
  end

  // Sums past 2^OW pin at 2^OW so bit OW stays a sticky overflow flag.
  assign suml   = (OW+2)'(accl) + (OW+2)'(tl);
  assign sumr   = (OW+2)'(accr) + (OW+2)'(tr);
  assign accl_n = suml[OW+1] ? {1'b1, {OW{1'b0}}} : suml[OW:0];
  assign accr_n = sumr[OW+1] ? {1'b1, {OW{1'b0}}} : sumr[OW:0];
  assign satl   = accl[OW] ? {OW{1'b1}} : accl[OW-1:0];
  assign satr   = accr[OW] ? {OW{1'b1}} : accr[OW-1:0];

`ifdef TS_PSG_MIXER_DCBLOCK_EN
  localparam logic signed [OW+2:0] SMAX = (OW+3)'((1 << (OW-1)) - 1);
  localparam logic signed [OW+2:0] SMIN = (OW+3)'(-(1 << (OW-1)));

  logic signed [OW+1:0] avgl, avgr, avgl_n, avgr_n;
  logic [OW-1:0]        outl, outr;

  function automatic logic signed [OW+1:0] dc_avg(
    input logic [OW-1:0]        x,
    input logic signed [OW+1:0] avg
  );
    logic signed [OW+2:0] diff;
    diff = $signed({3'b000, x}) - (OW+3)'(avg);
    return avg + (OW+2)'(diff >>> 8);
  endfunction

  function automatic logic [OW-1:0] dc_out(
    input logic [OW-1:0]        x,
    input logic signed [OW+1:0] avg
  );
    logic signed [OW+2:0] o;
    o = $signed({3'b000, x}) - (OW+3)'(avg);
    if (o > SMAX) return {1'b0, {(OW-1){1'b1}}};
    else if (o < SMIN) return {1'b1, {(OW-1){1'b0}}};
    else return o[OW-1:0];
  endfunction

  assign avgl_n = dc_avg(satl, avgl);
  assign avgr_n = dc_avg(satr, avgr);
  assign outl   = dc_out(satl, avgl_n);
  assign outr   = dc_out(satr, avgr_n);

  always_ff @(posedge clock) begin
    if (reset) begin
      avgl <= '0;
      avgr <= '0;
    end else if (state == DONE) begin
      avgl <= avgl_n;
      avgr <= avgr_n;
    end
  end
`else
  logic [OW-1:0] outl, outr;
  assign outl = satl;
  assign outr = satr;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      k       <= '0;
      pending <= 1'b0;
      mode_q  <= 2'd0;
      accl    <= '0;
      accr    <= '0;
      left    <= '0;
      right   <= '0;
      valid   <= 1'b0;
    end else begin
      state <= state_n;
      valid <= 1'b0;
      if (selWr && ((~d) < 8'(CHANNELS))) sel <= SW'(~d);
      // Any number of strobes during a sweep queue exactly one more sweep.
      if (ce && state != IDLE) pending <= 1'b1;
      if (start) begin
        accl    <= (OW+1)'(blvl);
        accr    <= (OW+1)'(blvl);
        k       <= '0;
        mode_q  <= mode;
        pending <= 1'b0;
      end
      if (state == ACC) begin
        accl <= accl_n;
        accr <= accr_n;
        k    <= k + 1'b1;
      end
      if (state == DONE) begin
        left  <= outl;
        right <= outr;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ts_psg_mixer.sv
// tb_ts_psg_mixer: scoreboard bench for ts_psg_mixer.
// Two instances (OW=16 and OW=14) share stimulus; outputs checked on valid.
module tb_ts_psg_mixer;

  localparam int CH = 2;
  localparam int DW = 12;

  logic             clock = 1'b0;
  logic             reset;
  logic             ce;
  logic [1:0]       mode;
  logic             selWr;
  logic [7:0]       d;
  logic [1:0]       beep;
  logic [CH*DW-1:0] psgA, psgB, psgC;
  logic [0:0]       sel0, sel1;
  logic [15:0]      left0, right0;
  logic [13:0]      left1, right1;
  logic             valid0, valid1;

  ts_psg_mixer #(.CHANNELS(CH), .DW(DW), .OW(16)) u0 (
    .clock(clock), .reset(reset), .ce(ce), .mode(mode),
    .selWr(selWr), .d(d), .sel(sel0), .beep(beep),
    .psgA(psgA), .psgB(psgB), .psgC(psgC),
    .left(left0), .right(right0), .valid(valid0)
  );

  ts_psg_mixer #(.CHANNELS(CH), .DW(DW), .OW(14)) u1 (
    .clock(clock), .reset(reset), .ce(ce), .mode(mode),
    .selWr(selWr), .d(d), .sel(sel1), .beep(beep),
    .psgA(psgA), .psgB(psgB), .psgC(psgC),
    .left(left1), .right(right1), .valid(valid1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int l0;
    int r0;
    int l1;
    int r1;
    int at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   la[CH], lb[CH], lc[CH];
  int   last_l0 = 0, last_r0 = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mix(input int md, input int bp, input int ow,
                             input bit rt);
    int s, cap;
    s = (bp == 3) ? 4095 : (bp == 2) ? 3874 : (bp == 1) ? 775 : 0;
    for (int i = 0; i < CH; i++) begin
      if (md == 0) s += rt ? 2*lc[i] + lb[i] : 2*la[i] + lb[i];
      else if (md == 1) s += rt ? 2*lb[i] + lc[i] : 2*la[i] + lc[i];
      else s += la[i] + lb[i] + lc[i];
    end
    cap = (1 << ow) - 1;
    return (s > cap) ? cap : s;
  endfunction

  function automatic exp_t mk(input int at);
    exp_t e;
    e.l0 = mix(int'(mode), int'(beep), 16, 1'b0);
    e.r0 = mix(int'(mode), int'(beep), 16, 1'b1);
    e.l1 = mix(int'(mode), int'(beep), 14, 1'b0);
    e.r1 = mix(int'(mode), int'(beep), 14, 1'b1);
    e.at = at;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_levels(input int a0, b0, c0, a1, b1, c1);
    la[0] = a0; lb[0] = b0; lc[0] = c0;
    la[1] = a1; lb[1] = b1; lc[1] = c1;
    for (int i = 0; i < CH; i++) begin
      psgA[i*DW +: DW] = DW'(la[i]);
      psgB[i*DW +: DW] = DW'(lb[i]);
      psgC[i*DW +: DW] = DW'(lc[i]);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain", q.size(), 0);
  endtask

  task automatic sweep(input bit scramble_mode);
    q.push_back(mk(cyc + CH + 2));
    ce = 1'b1;
    tick();
    ce = 1'b0;
    if (scramble_mode) mode = 2'($urandom_range(0, 3));
    drain();
  endtask

  task automatic sel_write(input logic [7:0] v);
    selWr = 1'b1;
    d = v;
    tick();
    selWr = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && (valid0 || valid1)) begin
      chk("valid_pair", 32'(valid1), 32'(valid0));
      chk("sb_nonempty", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.at);
        chk("left16", left0, e.l0);
        chk("right16", right0, e.r0);
        chk("left14", left1, e.l1);
        chk("right14", right1, e.r1);
        last_l0 = e.l0;
        last_r0 = e.r0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; ce = 1'b0; mode = 2'd0; selWr = 1'b0; d = 8'h00; beep = 2'd0;
    set_levels(0, 0, 0, 0, 0, 0);
    tick(); tick();
    @(negedge clock);
    chk("rst_sel", sel0, 0);
    chk("rst_left", left0, 0);
    chk("rst_right", right0, 0);
    chk("rst_valid", valid0, 0);
    tick();
    reset = 1'b0;

    sel_write(8'hFE);
    chk("sel_fe", sel0, 1);
    sel_write(8'hFD);
    chk("sel_fd", sel0, 1);
    sel_write(8'hFF);
    chk("sel_ff", sel0, 0);
    sel_write(8'hFE);
    reset = 1'b1;
    sel_write(8'hFE);
    reset = 1'b0;
    chk("sel_rst_wins", sel0, 0);

    set_levels(100, 10, 50, 0, 0, 0);
    mode = 2'd0; sweep(1'b0);
    chk("abc_left", left0, 210);
    mode = 2'd1; sweep(1'b0);
    chk("acb_left", left0, 250);
    mode = 2'd2; sweep(1'b0);
    chk("mono_right", right0, 160);
    mode = 2'd3; beep = 2'd3; sweep(1'b0);
    chk("beep_left", left0, 4255);

    set_levels(4095, 4095, 4095, 4095, 4095, 4095);
    mode = 2'd0; beep = 2'd3; sweep(1'b0);
    chk("sat14", left1, 16383);

    for (int i = 0; i < 8; i++) begin
      set_levels($urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095));
      mode = 2'($urandom_range(0, 3));
      beep = 2'($urandom_range(0, 3));
      sweep(1'b1);
    end
    repeat (3) tick();
    chk("hold_left", left0, last_l0);
    chk("hold_right", right0, last_r0);

    set_levels(300, 20, 7, 1, 2, 3);
    mode = 2'd1; beep = 2'd1;
    t = cyc;
    q.push_back(mk(t + 4));
    q.push_back(mk(t + 8));
    ce = 1'b1;
    tick(); tick(); tick();
    ce = 1'b0;
    drain();

    mode = 2'd0; beep = 2'd2;
    t = cyc;
    q.push_back(mk(t + 4));
    q.push_back(mk(t + 8));
    ce = 1'b1; tick(); ce = 1'b0;
    tick(); tick();
    ce = 1'b1; tick(); ce = 1'b0;
    drain();

    ce = 1'b1; tick(); ce = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (6) tick();
    chk("abort_left", left0, 0);
    chk("abort_right", right0, 0);
    chk("abort_sb", q.size(), 0);
    mode = 2'd2; beep = 2'd0;
    sweep(1'b0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
